lcd_nibble_sequencer: RTL and testbench

Sequences the 4-bit HD44780-style character LCD of the voice recorder. It runs the mandatory power-on initialisation, then accepts whole bytes (command or character) from the menu/status logic over a valid/ready handshake. It splits each byte into nibbles, generates the `en` strobe with setup, hold and execution delays, and drives `D1..D4`, `rs`, `rw` and `en` straight to the panel pins.

---
 rtl/lcd_pkg.sv | 57 +++++
 rtl/lcd_delay_timer.sv | 38 +++
 rtl/lcd_nibble_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_lcd_nibble_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types, init sequences and helpers for the 4-bit character LCD sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        INIT_NIB,
        INIT_BYTE,
        IDLE,
        SETUP,
        EN_HI,
        GAP,
        EXEC
    } lcd_state_e;

    localparam logic [7:0] LCD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_HOME  = 8'h02;

    localparam int INIT_NIB_N  = 4;
    localparam int INIT_BYTE_N = 4;

    // Nibble-only wake-up sequence that forces the panel into 4-bit mode.
    function automatic logic [3:0] init_nibble(input logic [1:0] idx);
        logic [3:0] nib;
        case (idx)
            2'd3:    nib = 4'h2;
            default: nib = 4'h3;
        endcase
        return nib;
    endfunction

    // Full-byte configuration: 2 lines 5x8, display on, entry increment, clear.
    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h28;
            2'd1:    b = 8'h0C;
            2'd2:    b = 8'h06;
            default: b = LCD_CLEAR;
        endcase
        return b;
    endfunction

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_slow_cmd(input logic rs_b, input logic [7:0] b);
        return !rs_b && ((b == LCD_CLEAR) || (b[7:1] == LCD_HOME[7:1]));
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the largest wait count.
    function automatic int timer_width(input int max_cyc);
        return (max_cyc < 1) ? 1 : $clog2(max_cyc + 1);
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter shared by every wait in the LCD sequencer.
// A load of N makes done fire in the Nth cycle after the load edge.
module lcd_delay_timer #(
    parameter int           W       = 19,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload on request (zero treated as one), else count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (load_val == '0) ? W'(1) : load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register; reset preloads the power-up wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == W'(1));

endmodule

// File: rtl/lcd_nibble_sequencer.sv
// HD44780-style 4-bit LCD sequencer: power-on init, then byte writes from a
// valid/ready requester, split into strobed nibbles with execution waits.
module lcd_nibble_sequencer
    import lcd_pkg::*;
#(
    parameter int PWRUP_CYC = 416667,
    parameter int INIT1_CYC = 113889,
    parameter int INIT2_CYC = 2778,
    parameter int CMD_CYC   = 1112,
    parameter int CLR_CYC   = 45556,
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 13,
    parameter int GAP_CYC   = 28
) (
    input  logic       clkout,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       D4,
    output logic       D3,
    output logic       D2,
    output logic       D1,
    output logic       rs,
    output logic       rw,
    output logic       en
);

    localparam int MAX_CYC = max_of(
        max_of(max_of(PWRUP_CYC, INIT1_CYC), max_of(INIT2_CYC, CMD_CYC)),
        max_of(max_of(CLR_CYC, SETUP_CYC), max_of(EN_CYC, GAP_CYC)));
    localparam int TW = timer_width(MAX_CYC);

    localparam logic [TW-1:0] T_PWRUP = TW'(PWRUP_CYC);
    localparam logic [TW-1:0] T_INIT1 = TW'(INIT1_CYC);
    localparam logic [TW-1:0] T_INIT2 = TW'(INIT2_CYC);
    localparam logic [TW-1:0] T_CMD   = TW'(CMD_CYC);
    localparam logic [TW-1:0] T_CLR   = TW'(CLR_CYC);
    localparam logic [TW-1:0] T_SETUP = TW'(SETUP_CYC);
    localparam logic [TW-1:0] T_EN    = TW'(EN_CYC);
    localparam logic [TW-1:0] T_GAP   = TW'(GAP_CYC);

    lcd_state_e  state_q, state_d;
    logic [1:0]  idx_q, idx_d;            // position in the current init list
    logic        nib_only_q, nib_only_d;  // current write is a lone init nibble
    logic        low_q, low_d;            // second (low) nibble of a byte in flight
    logic [7:0]  byte_q, byte_d;
    logic        rs_q, rs_d;
    logic [3:0]  dat_q, dat_d;
    logic        en_q, en_d;
    logic        ready_q, ready_d;
    logic        init_done_q, init_done_d;
    logic        tmr_load;
    logic [TW-1:0] tmr_val;
    logic        tmr_done;
    logic [7:0]  init_byte_w;

    assign init_byte_w = init_byte(idx_q);

    // Wait after a completed write: init nibbles use the staged wake-up delays,
    // bytes use the clear/home wait or the normal command wait.
    function automatic logic [TW-1:0] exec_len(input logic       nib_only,
                                               input logic [1:0] idx,
                                               input logic       rs_b,
                                               input logic [7:0] b);
        logic [TW-1:0] len;
        if (nib_only) begin
            case (idx)
                2'd0:    len = T_INIT1;
                2'd1:    len = T_INIT2;
                default: len = T_CMD;
            endcase
        end else if (is_slow_cmd(rs_b, b)) begin
            len = T_CLR;
        end else begin
            len = T_CMD;
        end
        return len;
    endfunction

    lcd_delay_timer #(
        .W       (TW),
        .RST_VAL (T_PWRUP)
    ) u_timer (
        .clk      (clkout),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Next-state, nibble mux, init index and timer reloads.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        nib_only_d  = nib_only_q;
        low_d       = low_q;
        byte_d      = byte_q;
        rs_d        = rs_q;
        dat_d       = dat_q;
        en_d        = en_q;
        init_done_d = init_done_q;
        tmr_load    = 1'b0;
        tmr_val     = T_SETUP;

        case (state_q)
            PWRUP: begin
                if (tmr_done) begin
                    idx_d   = 2'd0;
                    state_d = INIT_NIB;
                end
            end
            INIT_NIB: begin
                nib_only_d = 1'b1;
                rs_d       = 1'b0;
                dat_d      = init_nibble(idx_q);
                state_d    = SETUP;
                tmr_load   = 1'b1;
                tmr_val    = T_SETUP;
            end
            INIT_BYTE: begin
                nib_only_d = 1'b0;
                low_d      = 1'b0;
                rs_d       = 1'b0;
                byte_d     = init_byte_w;
                dat_d      = init_byte_w[7:4];
                state_d    = SETUP;
                tmr_load   = 1'b1;
                tmr_val    = T_SETUP;
            end
            IDLE: begin
                if (req_valid && ready_q) begin
                    nib_only_d = 1'b0;
                    low_d      = 1'b0;
                    rs_d       = req_rs;
                    byte_d     = req_data;
                    dat_d      = req_data[7:4];
                    state_d    = SETUP;
                    tmr_load   = 1'b1;
                    tmr_val    = T_SETUP;
                end
            end
            SETUP: begin
                if (tmr_done) begin
                    en_d     = 1'b1;
                    state_d  = EN_HI;
                    tmr_load = 1'b1;
                    tmr_val  = T_EN;
                end
            end
            EN_HI: begin
                if (tmr_done) begin
                    en_d     = 1'b0;
                    state_d  = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = T_GAP;
                end
            end
            GAP: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (!nib_only_q && !low_q) begin
                        low_d   = 1'b1;
                        dat_d   = byte_q[3:0];
                        state_d = SETUP;
                        tmr_val = T_SETUP;
                    end else begin
                        state_d = EXEC;
                        tmr_val = exec_len(nib_only_q, idx_q, rs_q, byte_q);
                    end
                end
            end
            EXEC: begin
                if (tmr_done) begin
                    if (init_done_q) begin
                        state_d = IDLE;
                    end else if (nib_only_q) begin
                        if (idx_q == 2'(INIT_NIB_N - 1)) begin
                            idx_d   = 2'd0;
                            state_d = INIT_BYTE;
                        end else begin
                            idx_d   = idx_q + 2'd1;
                            state_d = INIT_NIB;
                        end
                    end else if (idx_q == 2'(INIT_BYTE_N - 1)) begin
                        idx_d       = 2'd0;
                        init_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = INIT_BYTE;
                    end
                end
            end
            default: state_d = PWRUP;
        endcase

        ready_d = (state_d == IDLE) && init_done_d;
    end

    // Control and pin registers; reset returns to power-up with the pins low.
    always_ff @(posedge clkout) begin
        if (reset) begin
            state_q     <= PWRUP;
            idx_q       <= 2'd0;
            nib_only_q  <= 1'b1;
            low_q       <= 1'b0;
            rs_q        <= 1'b0;
            dat_q       <= 4'h0;
            en_q        <= 1'b0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            nib_only_q  <= nib_only_d;
            low_q       <= low_d;
            rs_q        <= rs_d;
            dat_q       <= dat_d;
            en_q        <= en_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
        end
    end

    // Latched byte being written; only read while a byte write is in flight.
    always_ff @(posedge clkout) begin
        byte_q <= byte_d;
    end

    assign req_ready = ready_q;
    assign init_done = init_done_q;
    assign D4        = dat_q[3];
    assign D3        = dat_q[2];
    assign D2        = dat_q[1];
    assign D1        = dat_q[0];
    assign rs        = rs_q;
    assign rw        = 1'b0;
    assign en        = en_q;

endmodule

// File: tb/tb_lcd_nibble_sequencer.sv
// Scoreboard bench for lcd_nibble_sequencer with short wait parameters.
module tb_lcd_nibble_sequencer;

    localparam int PWRUP = 20;
    localparam int INIT1 = 8;
    localparam int INIT2 = 6;
    localparam int CMD   = 10;
    localparam int CLR   = 30;
    localparam int SETUP = 2;
    localparam int ENC   = 3;
    localparam int GAPC  = 2;
    localparam int NIB_COST = SETUP + ENC + GAPC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, init_done, D4, D3, D2, D1, rs, rw, en;

    lcd_nibble_sequencer #(
        .PWRUP_CYC (PWRUP), .INIT1_CYC (INIT1), .INIT2_CYC (INIT2),
        .CMD_CYC (CMD), .CLR_CYC (CLR), .SETUP_CYC (SETUP),
        .EN_CYC (ENC), .GAP_CYC (GAPC)
    ) dut (
        .clkout (clk), .reset (reset), .req_valid (req_valid),
        .req_rs (req_rs), .req_data (req_data), .req_ready (req_ready),
        .init_done (init_done), .D4 (D4), .D3 (D3), .D2 (D2), .D1 (D1),
        .rs (rs), .rw (rw), .en (en)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    logic [4:0] exp_nib_q[$];   // {rs, nibble} expected on each en pulse
    int         exp_rdy_q[$];   // edge index at which req_ready must return
    int         last_rst_edge = 0;

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference: exec wait of a byte write.
    function automatic int exec_wait(input logic rs_b, input logic [7:0] b);
        return (!rs_b && (b == 8'h01 || b == 8'h02 || b == 8'h03)) ? CLR : CMD;
    endfunction

    task automatic push_init();
        logic [3:0] nibs [12];
        nibs = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};
        exp_nib_q.delete();
        exp_rdy_q.delete();
        for (int i = 0; i < 12; i++) exp_nib_q.push_back({1'b0, nibs[i]});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a byte and hold it until accepted; record expectations at the accept edge.
    task automatic send(input logic rs_b, input logic [7:0] b, input bit keep_valid);
        bit r;
        bit accepted;
        int budget;
        req_rs    = rs_b;
        req_data  = b;
        req_valid = 1'b1;
        accepted  = 1'b0;
        budget    = 0;
        while (!accepted && budget < 3000) begin
            r = req_ready;
            @(posedge clk);
            #1;
            if (r) accepted = 1'b1;
            budget++;
        end
        check("accept_within_budget", int'(accepted), 1);
        if (accepted) begin
            exp_nib_q.push_back({rs_b, b[7:4]});
            exp_nib_q.push_back({rs_b, b[3:0]});
            exp_rdy_q.push_back(cyc + 2 * NIB_COST + exec_wait(rs_b, b));
        end
        if (!keep_valid || !accepted) req_valid = 1'b0;
    endtask

    task automatic rand_byte(output logic rs_b, output logic [7:0] b);
        rs_b = 1'($urandom_range(0, 1));
        b    = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(1, 3));
        if (!rs_b && b == 8'h00) b = 8'h0C;
    endtask

    // Monitor: pops expectations whenever the panel pins show an en pulse or ready returns.
    logic       prev_en = 1'b0, prev_rdy = 1'b0, prev_done = 1'b0, acc_prev = 1'b0;
    logic [4:0] prev_bus = 5'd0, cur_bus, cap_bus = 5'd0;
    bit         moved = 1'b0;
    int         last_chg = -1000, hi_cnt = 0, init_pulses = 0, exp_done = -1;

    always @(negedge clk) begin
        cur_bus = {rs, D4, D3, D2, D1};
        if (reset) begin
            prev_en = 1'b0; prev_rdy = 1'b0; prev_done = 1'b0; acc_prev = 1'b0;
            hi_cnt = 0; init_pulses = 0; exp_done = -1;
        end else begin
            if (cur_bus != prev_bus) last_chg = cyc;
            if (!init_done) check("ready_held_off_during_init", int'(req_ready), 0);
            if (acc_prev) check("ready_drops_after_accept", int'(req_ready), 0);
            acc_prev = req_valid && req_ready;
            if (en && !prev_en) begin
                check("en_after_pwrup_wait", int'(cyc - last_rst_edge >= PWRUP), 1);
                check("setup_before_en", int'(cyc - last_chg >= SETUP), 1);
                check("rw_low", int'(rw), 0);
                check("en_pulse_expected", int'(exp_nib_q.size() > 0), 1);
                if (exp_nib_q.size() > 0) check("nibble_rs_data", int'(cur_bus), int'(exp_nib_q.pop_front()));
                cap_bus = cur_bus;
                moved   = 1'b0;
                hi_cnt  = 0;
            end
            if (en) begin
                hi_cnt++;
                if (cur_bus != cap_bus) moved = 1'b1;
            end
            if (!en && prev_en) begin
                check("en_width", hi_cnt, ENC);
                check("bus_stable_around_en", int'(moved || cur_bus != cap_bus), 0);
                if (!init_done) begin
                    init_pulses++;
                    if (init_pulses == 12) exp_done = cyc + GAPC + CLR;
                end
            end
            if (init_done && !prev_done) begin
                check("init_done_time", cyc, exp_done);
                check("init_pulse_count", init_pulses, 12);
                check("ready_with_init_done", int'(req_ready), 1);
            end
            if (req_ready && !prev_rdy && prev_done) begin
                check("ready_rise_expected", int'(exp_rdy_q.size() > 0), 1);
                if (exp_rdy_q.size() > 0) check("ready_return_cycle", cyc, exp_rdy_q.pop_front());
            end
            prev_en   = en;
            prev_rdy  = req_ready;
            prev_done = init_done;
        end
        prev_bus = cur_bus;
    end

    // Stimulus
    initial begin
        logic       r_rs;
        logic [7:0] r_b;
        int         budget;

        reset = 1'b1;
        step(1);
        check("reset_en", int'(en), 0);
        check("reset_rs_rw", int'({rs, rw}), 0);
        check("reset_data", int'({D4, D3, D2, D1}), 0);
        check("reset_ready", int'(req_ready), 0);
        check("reset_init_done", int'(init_done), 0);
        reset = 1'b0;
        last_rst_edge = cyc;
        push_init();

        // Character request issued during init must wait, then go through once.
        send(1'b1, 8'h41, 1'b0);
        step(3);
        send(1'b0, 8'h01, 1'b0);
        step(2);
        send(1'b0, 8'h80, 1'b0);
        step(1);

        // Back-to-back with valid held high.
        rand_byte(r_rs, r_b);
        send(r_rs, r_b, 1'b1);
        rand_byte(r_rs, r_b);
        send(r_rs, r_b, 1'b0);

        for (int i = 0; i < 8; i++) begin
            step($urandom_range(0, 5));
            rand_byte(r_rs, r_b);
            send(r_rs, r_b, ($urandom_range(0, 1) == 1));
        end
        req_valid = 1'b0;

        // Reset while en is high.
        rand_byte(r_rs, r_b);
        send(r_rs, r_b, 1'b0);
        budget = 0;
        while (!en && budget < 100) begin
            step(1);
            budget++;
        end
        check("en_seen_before_reset", int'(en), 1);
        reset = 1'b1;
        step(1);
        check("en_low_after_reset", int'(en), 0);
        check("init_done_cleared", int'(init_done), 0);
        check("ready_low_after_reset", int'(req_ready), 0);
        reset = 1'b0;
        last_rst_edge = cyc;
        push_init();

        rand_byte(r_rs, r_b);
        send(r_rs, r_b, 1'b0);
        rand_byte(r_rs, r_b);
        send(r_rs, r_b, 1'b0);

        budget = 0;
        while (exp_rdy_q.size() > 0 && budget < 500) begin
            step(1);
            budget++;
        end
        step(2);
        check("nibble_queue_drained", exp_nib_q.size(), 0);
        check("ready_queue_drained", exp_rdy_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
